// File: rtl/ddr_rd_sched.sv
// Read-burst scheduler: splits one read job into chunk-bounded reader commands,
// sequences the RSTART/RIDLE handshake and reports chunk count and elapsed cycles.
module ddr_rd_sched #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_BYTES = 4096
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start_reg,
  input  logic [31:0] base_addr,
  input  logic [31:0] total_bytes,
  output logic        rstart,
  output logic [31:0] raddr,
  output logic [31:0] rlength,
  input  logic        ridle,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] nchunk,
  output logic [31:0] cycles
);

  localparam int          BEAT_BYTES = DATA_WIDTH / 8;
  localparam logic [31:0] BEAT_MASK  = 32'(BEAT_BYTES - 1);
  localparam logic [31:0] CHUNK_MASK = 32'(CHUNK_BYTES - 1);
  localparam logic [32:0] CHUNK_LEN  = 33'(CHUNK_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_ACK,
    WAIT_IDLE,
    BOOK,
    DONE
  } state_t;

  state_t      state, state_next;
  logic        start_q, start_prev;
  logic [31:0] cur_addr;
  logic [31:0] remaining;

  logic        start_edge;
  logic        bad_job;
  logic [32:0] chunk_space;
  logic [31:0] chunk_len;
  logic [31:0] book_addr;
  logic        book_carry;
  logic [31:0] book_rem;
  logic        book_wrap;
  logic        counting;

  assign busy = (state != IDLE);

  always_comb begin
    start_edge  = start_q & ~start_prev;
    bad_job     = (remaining == '0) || ((cur_addr & BEAT_MASK) != '0) ||
                  ((remaining & BEAT_MASK) != '0);
    chunk_space = CHUNK_LEN - {1'b0, cur_addr & CHUNK_MASK};
    chunk_len   = ({1'b0, remaining} < chunk_space) ? remaining : chunk_space[31:0];
    {book_carry, book_addr} = {1'b0, cur_addr} + {1'b0, rlength};
    book_rem    = remaining - rlength;
    // A chunk ending exactly at 2^32 is legal; only a further chunk would wrap.
    book_wrap   = book_carry && (book_rem != '0);
    counting    = (state == CHECK) || (state == ISSUE) || (state == WAIT_ACK) ||
                  (state == WAIT_IDLE) || (state == BOOK);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start_edge) state_next = CHECK;
      CHECK:     state_next = bad_job ? DONE : ISSUE;
      ISSUE:     state_next = WAIT_ACK;
      WAIT_ACK:  if (!ridle) state_next = WAIT_IDLE;
      WAIT_IDLE: if (ridle) state_next = BOOK;
      BOOK:      state_next = ((book_rem == '0) || book_wrap) ? DONE : ISSUE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      start_prev <= 1'b0;
      cur_addr   <= '0;
      remaining  <= '0;
      rstart     <= 1'b0;
      raddr      <= '0;
      rlength    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      nchunk     <= '0;
      cycles     <= '0;
    end else begin
      state      <= state_next;
      start_q    <= start_reg;
      start_prev <= start_q;

      if (counting && (cycles != '1))
        cycles <= cycles + 32'd1;

      if ((state != DONE) && (state_next == DONE))
        done <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            cur_addr  <= base_addr;
            remaining <= total_bytes;
            done      <= 1'b0;
            err       <= 1'b0;
            nchunk    <= '0;
            cycles    <= '0;
          end
        end
        CHECK: begin
          if (bad_job)
            err <= 1'b1;
        end
        ISSUE: begin
          raddr   <= cur_addr;
          rlength <= chunk_len;
          rstart  <= 1'b1;
        end
        WAIT_ACK: begin
          if (!ridle)
            rstart <= 1'b0;
        end
        BOOK: begin
          cur_addr  <= book_addr;
          remaining <= book_rem;
          nchunk    <= nchunk + 16'd1;
          if (book_wrap)
            err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_sched.sv
// Scoreboard bench for ddr_rd_sched: a reader model pops expected commands as
// they are issued; job-level results are checked against a reference split model.
module tb_ddr_rd_sched;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start_reg = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] total_bytes = '0;
  logic        rstart;
  logic [31:0] raddr;
  logic [31:0] rlength;
  logic        ridle = 1'b1;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] nchunk;
  logic [31:0] cycles;

  int checks = 0;
  int errors = 0;
  int ack_dly = 2;
  int idle_dly = 512;
  int cmd_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] rd_cmd;
  bit          rd_abort;

  ddr_rd_sched #(.DATA_WIDTH(64), .CHUNK_BYTES(4096)) dut (
    .aclk(aclk), .aresetn(aresetn), .start_reg(start_reg),
    .base_addr(base_addr), .total_bytes(total_bytes),
    .rstart(rstart), .raddr(raddr), .rlength(rlength), .ridle(ridle),
    .busy(busy), .done(done), .err(err), .nchunk(nchunk), .cycles(cycles)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reader model: ack ack_dly cycles after rstart, return to idle idle_dly later.
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn && rstart && ridle) begin
        rd_cmd = {raddr, rlength};
        cmd_cnt++;
        if (exp_q.size() == 0) check("cmd_extra", 64'd1, 64'd0);
        else check("cmd", rd_cmd, exp_q.pop_front());
        rd_abort = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
          @(negedge aclk);
          if (!rstart) begin
            rd_abort = 1'b1;
            break;
          end
        end
        if (!rd_abort) begin
          check("cmd_hold", {raddr, rlength}, rd_cmd);
          ridle = 1'b0;
          repeat (idle_dly) @(negedge aclk);
          ridle = 1'b1;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rstart"}, rstart, 0);
    check({tag, "_raddr"}, raddr, 0);
    check({tag, "_rlength"}, rlength, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_nchunk"}, nchunk, 0);
    check({tag, "_cycles"}, cycles, 0);
  endtask

  task automatic run_job(input string tag, input logic [31:0] b, input logic [31:0] t,
                         input bit poke);
    logic [31:0] a, rem, len, sp;
    logic [32:0] sum;
    int n, exp_cyc, c0, k;
    bit e, go, poked;
    n = 0; e = 1'b0; poked = 1'b0;
    if (t == 0 || (b % 8) != 0 || (t % 8) != 0) e = 1'b1;
    else begin
      a = b; rem = t; go = 1'b1;
      while (go) begin
        sp  = 32'd4096 - (a % 32'd4096);
        len = (rem < sp) ? rem : sp;
        exp_q.push_back({a, len});
        n++;
        sum = {1'b0, a} + {1'b0, len};
        rem = rem - len;
        if (rem == 0) go = 1'b0;
        else if (sum[32]) begin e = 1'b1; go = 1'b0; end
        else a = sum[31:0];
      end
    end
    exp_cyc = 1 + n * (ack_dly + idle_dly + 3);
    c0 = cmd_cnt;

    base_addr = b; total_bytes = t; start_reg = 1'b1;
    repeat (3) @(negedge aclk);
    k = 0;
    while (!done && k < 20000) begin
      if (poke && !poked && busy && !rstart && !ridle) begin
        start_reg = 1'b0;
        @(negedge aclk);
        start_reg = 1'b1;
        poked = 1'b1;
      end
      @(negedge aclk);
      k++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_err"}, err, e);
    check({tag, "_nchunk"}, nchunk, n);
    check({tag, "_cycles"}, cycles, exp_cyc);
    check({tag, "_ncmd"}, cmd_cnt - c0, n);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_busy_done"}, busy, 1);
    if (poke) check({tag, "_poked"}, poked, 1);
    exp_q.delete();
    @(negedge aclk);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_done_hold"}, done, 1);
    repeat (10) @(negedge aclk);
    check({tag, "_no_rerun"}, busy, 0);
    check({tag, "_nchunk_hold"}, nchunk, n);
    check({tag, "_cycles_hold"}, cycles, exp_cyc);
    start_reg = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge aclk);
    check_all_zero("reset");
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    ack_dly = 2; idle_dly = 512;
    run_job("aligned", 32'h1000_0000, 32'd8192, 1'b0);

    idle_dly = 20;
    run_job("straddle", 32'h1000_0F00, 32'h300, 1'b0);
    run_job("zero_len", 32'h1000_0000, 32'd0, 1'b0);
    run_job("misalign", 32'h1000_0004, 32'd64, 1'b0);
    run_job("wrap", 32'hFFFF_F000, 32'd8192, 1'b0);
    run_job("poke", 32'h3000_0800, 32'd8192, 1'b1);

    // Reset while the first command waits for its acknowledge.
    ack_dly = 20;
    exp_q.push_back({32'h2000_0000, 32'd4096});
    base_addr = 32'h2000_0000; total_bytes = 32'd4096; start_reg = 1'b1;
    k = 0;
    while (!rstart && k < 50) begin
      @(negedge aclk);
      k++;
    end
    check("rst_rstart_seen", rstart, 1);
    repeat (3) @(negedge aclk);
    aresetn = 1'b0;
    start_reg = 1'b0;
    @(posedge aclk);
    #1;
    check_all_zero("midrst");
    @(negedge aclk);
    aresetn = 1'b1;
    ack_dly = 2;
    check("midrst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge aclk);
    run_job("after_rst", 32'h2000_0000, 32'd4096, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
